// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_pkg
// Brief    : Shared types and constants for the multi-port register bank.
// Revision : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

    localparam int c_xlen_default  = 64;
    localparam int c_nregs_default = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int addr_width(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_clear_fsm
// Brief    : Post-reset clear sequencer: walks every register once, then READY.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_clear_fsm
    import reg_bank_pkg::*;
#(
    parameter int NREGS = c_nregs_default,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_clr_ptr;
    logic [AW-1:0] w_clr_ptr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        case (r_state)
            CLEAR: begin
                w_clr_ptr_next = r_clr_ptr + AW'(1);
                if (r_clr_ptr == AW'(NREGS - 1)) begin
                    w_state_next = READY;
                end
            end
            READY: begin
                w_state_next = READY;
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    assign o_busy     = (r_state == CLEAR);
    // No clearing on the reset edge itself; the pointer is held at 0 there.
    assign o_clr_we   = (r_state == CLEAR) && !rst;
    assign o_clr_addr = r_clr_ptr;

endmodule
`default_nettype wire

// File: rtl/reg_bank_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_mp
// Brief    : Parametrised multi-read-port register bank with sequenced clear,
//            optional hardwired zero register and 1-cycle registered reads.
//            Define REG_BANK_BYPASS_EN to forward same-edge write data to reads.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int XLEN     = c_xlen_default,
    parameter int NREGS    = c_nregs_default,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               we,
    input  logic [addr_width(NREGS)-1:0]       waddr,
    input  logic [XLEN-1:0]                    wdata,
    input  logic [NRD-1:0]                     re,
    input  logic [NRD*addr_width(NREGS)-1:0]   raddr,
    output logic [NRD*XLEN-1:0]                rdata,
    output logic [NRD-1:0]                     rvalid,
    output logic                               busy
);

    localparam int AW = addr_width(NREGS);

    logic            w_busy;
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;
    logic            w_zero_wr;
    logic            w_user_we;
    logic [XLEN-1:0] r_regs [NREGS];

    reg_bank_clear_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign busy      = w_busy;
    assign w_zero_wr = (ZERO_REG != 0) && (waddr == '0);
    assign w_user_we = we && !w_busy && !rst && !w_zero_wr;

    // Clear writes own the array while the sequencer runs.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_regs[w_clr_addr] <= '0;
        end else if (w_user_we) begin
            r_regs[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   w_raddr;
        logic            w_zero_rd;
        logic [XLEN-1:0] w_rd_val;
        logic [XLEN-1:0] r_rdata;
        logic            r_rvalid;

        assign w_raddr   = raddr[p*AW +: AW];
        assign w_zero_rd = (ZERO_REG != 0) && (w_raddr == '0);

        always_comb begin
            w_rd_val = r_regs[w_raddr];
`ifdef REG_BANK_BYPASS_EN
            if (w_user_we && (w_raddr == waddr)) begin
                w_rd_val = wdata;
            end
`endif
            if (w_zero_rd) begin
                w_rd_val = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rdata  <= '0;
                r_rvalid <= 1'b0;
            end else if (!w_busy && re[p]) begin
                r_rdata  <= w_rd_val;
                r_rvalid <= 1'b1;
            end else begin
                r_rvalid <= 1'b0;
            end
        end

        assign rdata[p*XLEN +: XLEN] = r_rdata;
        assign rvalid[p]             = r_rvalid;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_mp
// Brief    : Self-checking bench: default bank (64b/32 regs/2 ports/zero reg)
//            and a small bank (32b/8 regs/4 ports/no zero reg) side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_mp;

    logic clk;
    logic rst;

    logic         we_a;
    logic [4:0]   waddr_a;
    logic [63:0]  wdata_a;
    logic [1:0]   re_a;
    logic [9:0]   raddr_a;
    logic [127:0] rdata_a;
    logic [1:0]   rvalid_a;
    logic         busy_a;

    logic         we_b;
    logic [2:0]   waddr_b;
    logic [31:0]  wdata_b;
    logic [3:0]   re_b;
    logic [11:0]  raddr_b;
    logic [127:0] rdata_b;
    logic [3:0]   rvalid_b;
    logic         busy_b;

    logic [63:0] mem_a [32];
    logic [63:0] prev_a [2];
    logic [31:0] mem_b [8];
    logic [31:0] prev_b [4];

    int n_checks;
    int n_fail;

    reg_bank_mp #(.XLEN(64), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .re(re_a), .raddr(raddr_a), .rdata(rdata_a), .rvalid(rvalid_a), .busy(busy_a)
    );

    reg_bank_mp #(.XLEN(32), .NREGS(8), .NRD(4), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .re(re_b), .raddr(raddr_b), .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we_a = 1'b0; re_a = '0; we_b = 1'b0; re_b = '0;
    endtask

    // Reference read: zero register first, then same-edge forwarding, else storage.
    function automatic logic [63:0] ref_read_a(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
`ifdef REG_BANK_BYPASS_EN
        if (we_a && waddr_a == a) return wdata_a;
`endif
        return mem_a[a];
    endfunction

    function automatic logic [31:0] ref_read_b(input logic [2:0] a);
`ifdef REG_BANK_BYPASS_EN
        if (we_b && waddr_b == a) return wdata_b;
`endif
        return mem_b[a];
    endfunction

    // One READY-state cycle: predict, update model, clock, compare.
    task automatic step();
        logic [63:0] exp_a [2];
        logic [1:0]  expv_a;
        logic [31:0] exp_b [4];
        logic [3:0]  expv_b;
        for (int p = 0; p < 2; p++) begin
            if (re_a[p]) prev_a[p] = ref_read_a(raddr_a[p*5 +: 5]);
            exp_a[p]  = prev_a[p];
            expv_a[p] = re_a[p];
        end
        for (int p = 0; p < 4; p++) begin
            if (re_b[p]) prev_b[p] = ref_read_b(raddr_b[p*3 +: 3]);
            exp_b[p]  = prev_b[p];
            expv_b[p] = re_b[p];
        end
        if (we_a && waddr_a != 5'd0) mem_a[waddr_a] = wdata_a;
        if (we_b) mem_b[waddr_b] = wdata_b;
        tick();
        chk("a_rvalid", 64'(rvalid_a), 64'(expv_a));
        for (int p = 0; p < 2; p++)
            chk($sformatf("a_rdata%0d", p), rdata_a[p*64 +: 64], exp_a[p]);
        chk("b_rvalid", 64'(rvalid_b), 64'(expv_b));
        for (int p = 0; p < 4; p++)
            chk($sformatf("b_rdata%0d", p), 64'(rdata_b[p*32 +: 32]), 64'(exp_b[p]));
    endtask

    task automatic reset_pulse();
        idle();
        rst = 1'b1;
        tick();
        chk("rst_busy_a", 64'(busy_a), 64'd1);
        chk("rst_busy_b", 64'(busy_b), 64'd1);
        chk("rst_rvalid_a", 64'(rvalid_a), 64'd0);
        chk("rst_rvalid_b", 64'(rvalid_b), 64'd0);
        chk("rst_rdata_a", rdata_a[63:0] | rdata_a[127:64], 64'd0);
        chk("rst_rdata_b", rdata_b[63:0] | rdata_b[127:64], 64'd0);
        rst = 1'b0;
    endtask

    // ncyc edges after reset release, hammering writes/reads that must be ignored.
    task automatic clear_phase(input int ncyc);
        for (int i = 1; i <= ncyc; i++) begin
            we_a = 1'b1; waddr_a = 5'd1; wdata_a = {$urandom, $urandom};
            re_a = 2'b11; raddr_a = 10'($urandom);
            we_b = (i <= 8); waddr_b = 3'd1; wdata_b = $urandom;
            re_b = (i <= 8) ? 4'hF : 4'h0; raddr_b = 12'($urandom);
            tick();
            chk($sformatf("clr_busy_a_%0d", i), 64'(busy_a), 64'(i < 32));
            chk($sformatf("clr_busy_b_%0d", i), 64'(busy_b), 64'(i < 8));
            chk("clr_rvalid_a", 64'(rvalid_a), 64'd0);
            chk("clr_rvalid_b", 64'(rvalid_b), 64'd0);
            chk("clr_rdata_a", rdata_a[63:0] | rdata_a[127:64], 64'd0);
            chk("clr_rdata_b", rdata_b[63:0] | rdata_b[127:64], 64'd0);
        end
        idle();
        for (int k = 0; k < 32; k++) mem_a[k] = '0;
        for (int k = 0; k < 8; k++) mem_b[k] = '0;
        for (int p = 0; p < 2; p++) prev_a[p] = '0;
        for (int p = 0; p < 4; p++) prev_b[p] = '0;
    endtask

    task automatic read_all_zero();
        for (int k = 0; k < 16; k++) begin
            idle();
            re_a = 2'b11;
            raddr_a = {5'(2*k + 1), 5'(2*k)};
            if (k < 2) begin
                re_b = 4'hF;
                raddr_b = {3'(4*k + 3), 3'(4*k + 2), 3'(4*k + 1), 3'(4*k)};
            end
            step();
        end
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        waddr_a = '0; wdata_a = '0; raddr_a = '0;
        waddr_b = '0; wdata_b = '0; raddr_b = '0;
        idle();
        tick();

        // Mid-clear reset, then a full clear.
        reset_pulse();
        clear_phase(10);
        reset_pulse();
        clear_phase(32);
        read_all_zero();

        // Basic write then read on both ports.
        we_a = 1'b1; waddr_a = 5'd5; wdata_a = 64'd36; step();
        waddr_a = 5'd6; wdata_a = 64'hFFFF_FFFF_FFFF_FFFE; step();
        idle(); re_a = 2'b11; raddr_a = {5'd6, 5'd5}; step();
        chk("wr_rd_r5", rdata_a[63:0], 64'd36);
        chk("wr_rd_r6", rdata_a[127:64], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wr_rd_rvalid", 64'(rvalid_a), 64'd3);

        // Zero register: discarded on bank A, ordinary on bank B.
        idle();
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 64'd45;
        we_b = 1'b1; waddr_b = 3'd0; wdata_b = 32'd45;
        step();
        idle(); re_a = 2'b01; raddr_a = '0; re_b = 4'b0001; raddr_b = '0; step();
        chk("zero_reg_a", rdata_a[63:0], 64'd0);
        chk("zero_reg_b", 64'(rdata_b[31:0]), 64'd45);

        // Same-edge read/write hazard.
        idle();
        we_a = 1'b1; waddr_a = 5'd3; wdata_a = 64'd7;
        we_b = 1'b1; waddr_b = 3'd3; wdata_b = 32'd7;
        step();
        wdata_a = 64'd11; wdata_b = 32'd11;
        re_a = 2'b01; raddr_a = 10'd3; re_b = 4'b0001; raddr_b = 12'd3;
        step();
`ifdef REG_BANK_BYPASS_EN
        chk("hazard_a", rdata_a[63:0], 64'd11);
        chk("hazard_b", 64'(rdata_b[31:0]), 64'd11);
`else
        chk("hazard_a", rdata_a[63:0], 64'd7);
        chk("hazard_b", 64'(rdata_b[31:0]), 64'd7);
`endif
        we_a = 1'b0; we_b = 1'b0; step();
        chk("hazard_next_a", rdata_a[63:0], 64'd11);
        chk("hazard_next_b", 64'(rdata_b[31:0]), 64'd11);

        // Four distinct reads on the small bank, then sparse enable.
        idle();
        for (int k = 4; k < 8; k++) begin
            we_b = 1'b1; waddr_b = 3'(k); wdata_b = 32'(100 + k); step();
        end
        idle(); re_b = 4'hF; raddr_b = {3'd7, 3'd6, 3'd5, 3'd4}; step();
        for (int p = 0; p < 4; p++)
            chk($sformatf("b4_port%0d", p), 64'(rdata_b[p*32 +: 32]), 64'(104 + p));
        re_b = 4'b0101; raddr_b = {3'd4, 3'd5, 3'd6, 3'd7}; step();
        chk("b4_sparse_rvalid", 64'(rvalid_b), 64'h5);
        chk("b4_sparse_p0", 64'(rdata_b[31:0]), 64'd107);
        chk("b4_sparse_p1_hold", 64'(rdata_b[63:32]), 64'd105);

        // Randomised traffic, addresses biased toward collisions.
        for (int n = 0; n < 300; n++) begin
            we_a = 1'($urandom); waddr_a = 5'($urandom_range(0, 7));
            wdata_a = {$urandom, $urandom}; re_a = 2'($urandom);
            for (int p = 0; p < 2; p++) raddr_a[p*5 +: 5] = 5'($urandom_range(0, 7));
            we_b = 1'($urandom); waddr_b = 3'($urandom);
            wdata_b = $urandom; re_b = 4'($urandom);
            raddr_b = 12'($urandom);
            step();
        end

        // Reset from READY must wipe everything.
        reset_pulse();
        clear_phase(32);
        read_all_zero();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
